// File: rtl/ro_heater_scheduler.sv
// ============================================================================
// Module   : ro_heater_scheduler
// Brief    : Staggered ramp-up / hold / ramp-down sequencer for RO heater banks,
//            commanded by one AXI-Stream word. Optional HOLD duty gating is
//            enabled by defining RO_HEATER_SCHED_DUTY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_heater_scheduler #(
    parameter int NUM_HEATERS  = 5,
    parameter int C_DATA_WIDTH = 32,
    parameter int RAMP_STEP    = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [C_DATA_WIDTH-1:0] s_tdata,
    input  logic                    abort,
    input  logic [15:0]             duty_on_cycles,
    input  logic [15:0]             duty_off_cycles,
    output logic [NUM_HEATERS-1:0]  heater_enable,
    output logic [4:0]              active_level,
    output logic                    busy,
    output logic                    done
);

    localparam int                     c_STEP_W    = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;
    localparam logic [c_STEP_W-1:0]    c_STEP_LAST = c_STEP_W'(RAMP_STEP - 1);
    localparam logic [7:0]             c_NUM_H8    = 8'(NUM_HEATERS);
    localparam logic [4:0]             c_NUM_H5    = 5'(NUM_HEATERS);
    localparam logic [NUM_HEATERS-1:0] c_ALL       = {NUM_HEATERS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [4:0]          r_level, w_level_nxt;
    logic [4:0]          r_tgt,   w_tgt_nxt;
    logic [c_STEP_W-1:0] r_step,  w_step_nxt;
    logic [23:0]         r_dur,   w_dur_nxt;
    logic                r_done,  w_done_nxt;
    logic                r_busy;

    logic                w_accept;
    logic [4:0]          w_cmd_lvl;
    logic                w_step_wrap;
    logic [c_STEP_W-1:0] w_step_inc;
    logic                w_hold_entry;
    logic                w_gate;
    logic [NUM_HEATERS-1:0] w_pattern;

    assign s_tready    = (r_state == ST_IDLE) && !rst;
    assign w_accept    = s_tvalid && s_tready;
    assign w_cmd_lvl   = (s_tdata[7:0] > c_NUM_H8) ? c_NUM_H5 : s_tdata[4:0];
    assign w_step_wrap = (r_step == c_STEP_LAST);
    assign w_step_inc  = w_step_wrap ? '0 : r_step + c_STEP_W'(1);
    assign w_hold_entry = (r_state == ST_RAMP_UP) && !abort && (r_level == r_tgt);

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_tgt_nxt   = r_tgt;
        w_step_nxt  = r_step;
        w_dur_nxt   = r_dur;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_dur_nxt  = s_tdata[31:8];
                    w_step_nxt = '0;
                    if (w_cmd_lvl == 5'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RAMP_UP;
                        w_level_nxt = 5'd1;
                        w_tgt_nxt   = w_cmd_lvl;
                    end
                end
            end
            ST_RAMP_UP: begin
                if (abort) begin
                    w_state_nxt = ST_RAMP_DOWN;
                    w_step_nxt  = '0;
                end else if (r_level == r_tgt) begin
                    w_state_nxt = ST_HOLD;
                    w_step_nxt  = '0;
                end else begin
                    w_step_nxt = w_step_inc;
                    if (w_step_wrap) begin
                        w_level_nxt = r_level + 5'd1;
                    end
                end
            end
            ST_HOLD: begin
                // A zero duration holds until abort.
                if (abort || (r_dur == 24'd1)) begin
                    w_state_nxt = ST_RAMP_DOWN;
                    w_step_nxt  = '0;
                end else if (r_dur != 24'd0) begin
                    w_dur_nxt = r_dur - 24'd1;
                end
            end
            ST_RAMP_DOWN: begin
                // Step count 0 marks a drop, so the first edge in state drops a bank.
                w_step_nxt = w_step_inc;
                if (r_step == '0) begin
                    w_level_nxt = r_level - 5'd1;
                    if (r_level == 5'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                        w_step_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_level <= 5'd0;
            r_tgt   <= 5'd0;
            r_step  <= '0;
            r_dur   <= 24'd0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_tgt   <= w_tgt_nxt;
            r_step  <= w_step_nxt;
            r_dur   <= w_dur_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef RO_HEATER_SCHED_DUTY_EN
    logic [15:0] r_on_len,   w_on_len_nxt;
    logic [15:0] r_off_len,  w_off_len_nxt;
    logic [15:0] r_duty_cnt, w_duty_cnt_nxt;
    logic        r_duty_off, w_duty_off_nxt;
    logic [16:0] w_cnt_p1;

    assign w_cnt_p1 = {1'b0, r_duty_cnt} + 17'd1;

    always_comb begin
        w_on_len_nxt   = r_on_len;
        w_off_len_nxt  = r_off_len;
        w_duty_cnt_nxt = r_duty_cnt;
        w_duty_off_nxt = r_duty_off;
        if (w_hold_entry) begin
            w_on_len_nxt   = duty_on_cycles;
            w_off_len_nxt  = duty_off_cycles;
            w_duty_cnt_nxt = 16'd0;
            w_duty_off_nxt = 1'b0;
        end else if ((r_state == ST_HOLD) && (r_off_len != 16'd0)) begin
            if (w_cnt_p1 >= {1'b0, (r_duty_off ? r_off_len : r_on_len)}) begin
                w_duty_cnt_nxt = 16'd0;
                w_duty_off_nxt = !r_duty_off;
            end else begin
                w_duty_cnt_nxt = w_cnt_p1[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_on_len   <= 16'd0;
            r_off_len  <= 16'd0;
            r_duty_cnt <= 16'd0;
            r_duty_off <= 1'b0;
        end else begin
            r_on_len   <= w_on_len_nxt;
            r_off_len  <= w_off_len_nxt;
            r_duty_cnt <= w_duty_cnt_nxt;
            r_duty_off <= w_duty_off_nxt;
        end
    end

    // Gating applies only inside HOLD, so leaving HOLD mid off-phase restores the banks.
    assign w_gate = (r_state == ST_HOLD) && r_duty_off;
`else
    logic w_unused_duty;
    assign w_unused_duty = ^{duty_on_cycles, duty_off_cycles, w_hold_entry};
    assign w_gate        = 1'b0;
`endif

    assign w_pattern     = ~(c_ALL >> r_level);
    assign heater_enable = w_pattern & ~{NUM_HEATERS{w_gate}};
    assign active_level  = r_level;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

`default_nettype wire
